// File: rtl/lut_function_engine.sv
// rtl/lut_function_engine.sv - programmable truth-table evaluator with row-by-row config load
module lut_function_engine #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cfg_start_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [N_OUT-1:0] cfg_data_i,
  output logic             loaded_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N_IN-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N_OUT-1:0] out_data_o
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  ptr_q, ptr_d;
  logic             loaded_q, loaded_d;
  logic             out_valid_q, out_valid_d;
  logic [N_OUT-1:0] out_data_q, out_data_d;
  logic [N_OUT-1:0] table_q [DEPTH];
  logic             tbl_we;
  logic             cfg_fire, in_fire;

  // A start pulse owns the cycle: it blocks both the config beat and any input accept.
  assign cfg_ready_o = (state_q == S_LOAD) && !cfg_start_i;
  assign in_ready_o  = (state_q == S_RUN) && !cfg_start_i && (!out_valid_q || out_ready_i);
  assign cfg_fire    = cfg_valid_i && cfg_ready_o;
  assign in_fire     = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    loaded_d    = loaded_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    tbl_we      = 1'b0;
    if (cfg_start_i) begin
      state_d     = S_LOAD;
      ptr_d       = '0;
      loaded_d    = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (cfg_fire) begin
            tbl_we = 1'b1;
            if (ptr_q == PTR_LAST) begin
              state_d  = S_RUN;
              loaded_d = 1'b1;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (in_fire) begin
            out_data_d  = table_q[in_data_i];
            out_valid_d = 1'b1;
          end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      loaded_q    <= loaded_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (tbl_we) begin
      table_q[ptr_q] <= cfg_data_i;
    end
  end

  assign loaded_o    = loaded_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_lut_function_engine.sv
// tb/tb_lut_function_engine.sv - randomized and directed checks of lut_function_engine against a table model
module tb_lut_function_engine;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_start, cfg_valid, cfg_ready;
  logic [N_OUT-1:0] cfg_data;
  logic             loaded;
  logic             in_valid, in_ready;
  logic [N_IN-1:0]  in_data;
  logic             out_valid, out_ready;
  logic [N_OUT-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N_OUT-1:0] tab [DEPTH];
  logic [N_OUT-1:0] rows [DEPTH];
  logic [N_OUT-1:0] exp_q [$];
  int               vecs [$];

  lut_function_engine #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cfg_start_i (cfg_start),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_data_i  (cfg_data),
    .loaded_o    (loaded),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_loaded"}, loaded, 0);
    check({tag, "_cfg_ready"}, cfg_ready, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  // Loads rows[] with an optional 3-cycle stall at stall_at and an optional reset after abort_at rows.
  task automatic load(input int stall_at, input int abort_at);
    int i, stalls, guard;
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = ~rows[0];
    #1;
    check("start_cfg_ready", cfg_ready, 0);
    check("start_in_ready", in_ready, 0);
    tick();
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    exp_q.delete();
    check("start_out_valid", out_valid, 0);
    check("start_loaded", loaded, 0);
    check("start_in_ready_after", in_ready, 0);
    i = 0; stalls = 0; guard = 0;
    while (i < DEPTH && guard < 200) begin
      guard++;
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        for (int k = 0; k < DEPTH; k++) tab[k] = '0;
        cfg_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        check_reset_outputs("after_rst");
        return;
      end
      if (i == stall_at && stalls < 3) begin
        cfg_valid = 1'b0;
        stalls++;
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = rows[i];
      end
      #1;
      check("load_cfg_ready", cfg_ready, 1);
      check("load_loaded_low", loaded, 0);
      tick();
      if (cfg_valid) i++;
    end
    cfg_valid = 1'b0;
    check("load_beats", i, DEPTH);
    check("load_loaded_high", loaded, 1);
    check("load_cfg_ready_end", cfg_ready, 0);
    check("load_in_ready", in_ready, 1);
    for (int k = 0; k < DEPTH; k++) tab[k] = rows[k];
  endtask

  task automatic run_stream(input bit rnd);
    int k, guard;
    logic fi, fo;
    k = 0; guard = 0;
    while ((k < vecs.size() || exp_q.size() != 0) && guard < 2000) begin
      guard++;
      in_valid  = (k < vecs.size()) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data   = (k < vecs.size()) ? vecs[k][N_IN-1:0] : N_IN'($urandom);
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      check("sb_out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("sb_out_data", out_data, exp_q[0]);
      check("sb_in_ready", in_ready, (exp_q.size() == 0) || out_ready);
      fi = in_valid && in_ready;
      fo = out_valid && out_ready;
      tick();
      if (fo && exp_q.size() != 0) void'(exp_q.pop_front());
      if (fi) begin
        exp_q.push_back(tab[vecs[k]]);
        k++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("sb_all_consumed", k, vecs.size());
  endtask

  task automatic all_vectors();
    vecs.delete();
    for (int v = 0; v < DEPTH; v++) vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) tab[k] = '0;

    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("idle");

    for (int k = 0; k < DEPTH; k++) rows[k] = N_OUT'(k % 8);
    load(-1, -1);

    vecs.delete();
    vecs.push_back(10); vecs.push_back(3); vecs.push_back(15);
    run_stream(1'b0);
    check("stream_row_A", tab[10], 2);

    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h5;
    #1;
    check("bp_accept_ready", in_ready, 1);
    tick();
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 5);
    in_data = 4'h9;
    #1;
    check("bp_in_ready_low", in_ready, 0);
    tick();
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_data", out_data, 5);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    tick();
    check("bp_next_data", out_data, 1);
    check("bp_next_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("bp_drain", out_valid, 0);

    for (int k = 0; k < DEPTH; k++) rows[k] = N_OUT'($urandom);
    load(7, -1);
    all_vectors();
    run_stream(1'b0);
    vecs.delete();
    for (int j = 0; j < 40; j++) vecs.push_back($urandom_range(0, DEPTH - 1));
    run_stream(1'b1);

    out_ready = 1'b0; in_valid = 1'b1; in_data = N_IN'($urandom);
    tick();
    check("reload_pending", out_valid, 1);
    for (int k = 0; k < DEPTH; k++) rows[k] = 3'h7;
    load(-1, -1);
    out_ready = 1'b1;
    all_vectors();
    run_stream(1'b0);

    for (int k = 0; k < DEPTH; k++) rows[k] = N_OUT'($urandom);
    load(-1, 5);
    for (int k = 0; k < DEPTH; k++) rows[k] = N_OUT'($urandom);
    load(-1, -1);
    all_vectors();
    run_stream(1'b0);
    vecs.delete();
    for (int j = 0; j < 40; j++) vecs.push_back($urandom_range(0, DEPTH - 1));
    run_stream(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
